// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared constants and helpers for the NES button event path
package nes_pkg;

    localparam int NES_BUTTONS = 8;

    // Button indices; index i corresponds to controller_data[7-i].
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Event word layout: {pressed, index[2:0]}.
    localparam int EVT_W         = 4;
    localparam int EVT_PRESSED   = 3;
    localparam int EVT_INDEX_MSB = 2;
    localparam int EVT_INDEX_LSB = 0;
    localparam int EVT_INDEX_W   = EVT_INDEX_MSB - EVT_INDEX_LSB + 1;

    typedef struct packed {
        logic                   pressed;
        logic [EVT_INDEX_W-1:0] index;
    } nes_event_t;

    // Lowest set bit position of a mask held in button-index order (A first).
    function automatic logic [EVT_INDEX_W-1:0] lowest_set(input logic [NES_BUTTONS-1:0] v);
        logic [EVT_INDEX_W-1:0] idx;
        idx = EVT_INDEX_W'(BTN_A);
        for (int i = NES_BUTTONS - 1; i >= 0; i--) begin
            if (v[i]) idx = EVT_INDEX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nes_event_fifo.sv
// rtl/nes_event_fifo.sv - synchronous show-ahead FIFO with push/pop/full/empty/level
// Ports: clock, reset (async active-low), push/push_data, pop/pop_data,
//        full, empty, level (occupancy, clog2(DEPTH)+1 bits).
module nes_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    // Full is judged on the registered level, so a pop does not make room
    // for a push in the same cycle.
    assign full    = (level_q == (AW + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Storage is not reset; mask the head so the output reads 0 when empty.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = level_q;

endmodule

// File: rtl/nes_button_events.sv
// rtl/nes_button_events.sv - debounce NES buttons and queue press/release events
// Ports: clock, reset (async active-low), controller_data[7:0] (bit 7 = A),
//        event_ready in; event_valid, event_data {pressed,index}, buttons_stable,
//        fifo_level out.
module nes_button_events
    import nes_pkg::*;
#(
    parameter int STABLE_CYCLES = 200000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NES_BUTTONS-1:0]        controller_data,
    input  logic                          event_ready,
    output logic                          event_valid,
    output logic [EVT_W-1:0]              event_data,
    output logic [NES_BUTTONS-1:0]        buttons_stable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);

    logic [NES_BUTTONS-1:0] sync_meta_q, sync_q;
    logic [NES_BUTTONS-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NES_BUTTONS-1:0] stable_q, stable_d;
    logic [NES_BUTTONS-1:0] change_q, change_d;
    logic [NES_BUTTONS-1:0] pending_q, pending_d;

    logic [NES_BUTTONS-1:0] change_idx;
    logic [NES_BUTTONS-1:0] emit_onehot;
    logic [EVT_INDEX_W-1:0] emit_idx;
    logic                   emit;
    logic                   fifo_full, fifo_empty;
    nes_event_t             push_evt;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            // The cycle that would bring the count to STABLE_CYCLES-1 commits,
            // giving exactly STABLE_CYCLES matching samples including the load.
            if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
                stable_d = cand_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
        change_d = stable_d ^ stable_q;
    end

    // Pending mask is kept in button-index order so the lowest bit is A.
    always_comb begin
        change_idx = '0;
        for (int i = 0; i < NES_BUTTONS; i++) change_idx[i] = change_q[NES_BUTTONS-1-i];
    end

    always_comb begin
        emit        = (pending_q != '0) && !fifo_full;
        emit_idx    = lowest_set(pending_q);
        emit_onehot = emit ? (NES_BUTTONS'(1) << emit_idx) : '0;
        // XOR lets a double toggle cancel and lets a same-cycle change re-arm.
        pending_d   = (pending_q & ~emit_onehot) ^ change_idx;
        push_evt.pressed = stable_q[3'(NES_BUTTONS - 1) - emit_idx];
        push_evt.index   = emit_idx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            change_q    <= '0;
            pending_q   <= '0;
        end else begin
            sync_meta_q <= controller_data;
            sync_q      <= sync_meta_q;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            change_q    <= change_d;
            pending_q   <= pending_d;
        end
    end

    nes_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (emit),
        .push_data (push_evt),
        .pop       (event_ready),
        .pop_data  (event_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign event_valid    = !fifo_empty;
    assign buttons_stable = stable_q;

endmodule
